// File: rtl/wide_op_seq.sv
// Sequences a 16-bit operation as two byte passes through an external 8-bit ALU,
// chaining the shift/carry bit between passes and assembling the registered result.

package wide_op_seq_pkg;
  // Opcode 0 is the ALU no-op; 6 and 7 are unused and treated as illegal.
  localparam logic [2:0] kADD = 3'd1;
  localparam logic [2:0] kSUB = 3'd2;
  localparam logic [2:0] kLSH = 3'd3;
  localparam logic [2:0] kRSH = 3'd4;
  localparam logic [2:0] kAND = 3'd5;
  localparam logic [2:0] kNOP = 3'd0;
endpackage

module wide_op_seq
  import wide_op_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [2:0]  opw_i,
  input  logic [15:0] a16_i,
  input  logic [15:0] b16_i,
  input  logic        cin_i,
  output logic [7:0]  alu_a_o,
  output logic [7:0]  alu_b_o,
  output logic [2:0]  alu_op_o,
  output logic        alu_sc_in_o,
  input  logic [7:0]  alu_out_i,
  input  logic        alu_sc_out_i,
  output logic [15:0] result_o,
  output logic        cout_o,
  output logic        zero16_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {StIdle, StFirst, StSecond, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [15:0] a_q, b_q;
  logic        cin_q;
  logic        sc_q;
  logic [15:0] result_q;
  logic        cout_q;
  logic        done_q;

  logic        accept;
  logic        busy;
  logic        op_legal;
  logic        sel_hi;
  logic [7:0]  a_byte, b_byte;
  logic [7:0]  res_byte;
  logic        res_sc;

  assign accept   = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign busy     = (state_q == StFirst) || (state_q == StSecond);
  assign op_legal = op_q inside {kADD, kSUB, kLSH, kRSH, kAND};

  // Right shifts walk high byte first so the shift-in bit travels downwards.
  assign sel_hi = (state_q == StFirst) ? (op_q == kRSH) : (op_q != kRSH);
  assign a_byte = sel_hi ? a_q[15:8] : a_q[7:0];
  assign b_byte = sel_hi ? b_q[15:8] : b_q[7:0];

  // Illegal ops write zeros regardless of what the ALU returns.
  assign res_byte = op_legal ? alu_out_i : 8'h00;
  assign res_sc   = op_legal ? alu_sc_out_i : 1'b0;

  // Next-state logic for the two-pass sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_i) state_d = StFirst;
      StFirst:  state_d = StSecond;
      StSecond: state_d = StDone;
      StDone:   state_d = start_i ? StFirst : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ALU drive: zero outside the two busy passes and for illegal ops.
  always_comb begin
    alu_a_o     = 8'h00;
    alu_b_o     = 8'h00;
    alu_op_o    = kNOP;
    alu_sc_in_o = 1'b0;
    if (busy && op_legal) begin
      alu_a_o = a_byte;
      unique case (op_q)
        kADD: begin
          alu_op_o = kADD;
          alu_b_o  = b_byte;
        end
        kSUB: begin
          // A - B as A + ~B + 1, borrow chained through the carry.
          alu_op_o = kADD;
          alu_b_o  = ~b_byte;
        end
        kLSH, kRSH: begin
          alu_op_o = op_q;
        end
        kAND: begin
          alu_op_o = kAND;
          alu_b_o  = b_byte;
        end
        default: begin
          alu_op_o = kNOP;
        end
      endcase
      if (state_q == StFirst) begin
        unique case (op_q)
          kADD, kLSH, kRSH: alu_sc_in_o = cin_q;
          kSUB:             alu_sc_in_o = 1'b1;
          default:          alu_sc_in_o = 1'b0;
        endcase
      end else begin
        alu_sc_in_o = sc_q;
      end
    end
  end

  // Operand capture, inter-pass carry, result assembly and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= kNOP;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      cin_q    <= 1'b0;
      sc_q     <= 1'b0;
      result_q <= 16'h0000;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == StSecond);
      if (accept) begin
        op_q  <= opw_i;
        a_q   <= a16_i;
        b_q   <= b16_i;
        cin_q <= cin_i;
      end
      if (busy) begin
        if (sel_hi) begin
          result_q[15:8] <= res_byte;
        end else begin
          result_q[7:0] <= res_byte;
        end
      end
      if (state_q == StFirst) begin
        sc_q <= res_sc;
      end
      if (state_q == StSecond) begin
        cout_q <= res_sc;
      end
    end
  end

  assign result_o = result_q;
  assign cout_o   = cout_q;
  assign zero16_o = (result_q == 16'h0000);
  assign busy_o   = busy;
  assign done_o   = done_q;

endmodule

// File: tb/tb_wide_op_seq.sv
// Self-checking bench for wide_op_seq: behavioural 8-bit ALU plus a 16-bit arithmetic
// reference model; randomized and directed operations are checked against that model.

module tb_wide_op_seq;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_LSH = 3'd3;
  localparam logic [2:0] OP_RSH = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  opw;
  logic [15:0] a16, b16;
  logic        cin;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [2:0]  alu_op;
  logic        alu_sc_in, alu_sc_out;
  logic [15:0] result;
  logic        cout, zero16, busy, done;
  logic [8:0]  alu_sum;

  int errors = 0;
  int checks = 0;
  logic [15:0] prev_result = 16'h0000;
  logic        prev_cout = 1'b0;

  always #5 clk = ~clk;

  wide_op_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .opw_i        (opw),
    .a16_i        (a16),
    .b16_i        (b16),
    .cin_i        (cin),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_op_o     (alu_op),
    .alu_sc_in_o  (alu_sc_in),
    .alu_out_i    (alu_out),
    .alu_sc_out_i (alu_sc_out),
    .result_o     (result),
    .cout_o       (cout),
    .zero16_o     (zero16),
    .busy_o       (busy),
    .done_o       (done)
  );

  // Downstream 8-bit ALU.
  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_sc_in};
  always_comb begin
    alu_out    = 8'h00;
    alu_sc_out = 1'b0;
    case (alu_op)
      OP_ADD: {alu_sc_out, alu_out} = alu_sum;
      OP_LSH: begin alu_out = {alu_a[6:0], alu_sc_in}; alu_sc_out = alu_a[7]; end
      OP_RSH: begin alu_out = {alu_sc_in, alu_a[7:1]}; alu_sc_out = alu_a[0]; end
      OP_AND: alu_out = alu_a & alu_b;
      default: ;
    endcase
  end

  // 16-bit reference computed directly from the operation definitions.
  function automatic void ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic c, output logic [15:0] r, output logic co);
    logic [16:0] s;
    r  = 16'h0000;
    co = 1'b0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b} + {16'd0, c}; r = s[15:0]; co = s[16]; end
      OP_SUB: begin r = a - b; co = (a >= b); end
      OP_LSH: begin r = {a[14:0], c}; co = a[15]; end
      OP_RSH: begin r = {c, a[15:1]}; co = a[0]; end
      OP_AND: r = a & b;
      default: ;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_AND);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation from IDLE or DONE, checked through each state; ends in DONE.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic c);
    logic [15:0] exp_r, part;
    logic        exp_c, first_hi;
    logic [2:0]  exp_op;
    ref_op(op, a, b, c, exp_r, exp_c);
    first_hi = (op == OP_RSH);
    part = prev_result;
    if (first_hi) part[15:8] = exp_r[15:8];
    else          part[7:0]  = exp_r[7:0];
    exp_op = !is_legal(op) ? 3'd0 : (op == OP_SUB) ? OP_ADD : op;
    opw = op; a16 = a; b16 = b; cin = c; start = 1'b1;
    step();
    // Scramble inputs to show the operands were captured.
    start = 1'b0; opw = 3'($urandom); a16 = 16'($urandom); b16 = 16'($urandom); cin = 1'($urandom);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL first_state op=%0d busy=%b done=%b required busy=1 done=0", op, busy, done);
    end
    checks++;
    if (alu_op !== exp_op) begin
      errors++;
      $display("FAIL first_alu_op op=%0d got %0d required %0d", op, alu_op, exp_op);
    end
    if (is_legal(op)) begin
      checks++;
      if (alu_a !== (first_hi ? a[15:8] : a[7:0])) begin
        errors++;
        $display("FAIL first_alu_a op=%0d got %h required %h", op, alu_a,
                 first_hi ? a[15:8] : a[7:0]);
      end
    end
    step();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || alu_op !== exp_op) begin
      errors++;
      $display("FAIL second_state op=%0d busy=%b done=%b alu_op=%0d required 1 0 %0d",
               op, busy, done, alu_op, exp_op);
    end
    checks++;
    if (result !== part || cout !== prev_cout) begin
      errors++;
      $display("FAIL partial op=%0d got %h/%b required %h/%b", op, result, cout, part, prev_cout);
    end
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse op=%0d done=%b busy=%b required done=1 busy=0", op, done, busy);
    end
    checks++;
    if (result !== exp_r || cout !== exp_c || zero16 !== (exp_r == 16'h0000)) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h c=%b got %h/%b/z%b required %h/%b/z%b", op, a, b, c,
               result, cout, zero16, exp_r, exp_c, exp_r == 16'h0000);
    end
    checks++;
    if (alu_op !== 3'd0 || alu_a !== 8'h00 || alu_b !== 8'h00 || alu_sc_in !== 1'b0) begin
      errors++;
      $display("FAIL done_alu_idle got op=%0d a=%h b=%h sc=%b required all 0",
               alu_op, alu_a, alu_b, alu_sc_in);
    end
    prev_result = exp_r;
    prev_cout   = exp_c;
  endtask

  task automatic idle_check();
    start = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== prev_result) begin
      errors++;
      $display("FAIL idle done=%b busy=%b result=%h required 0 0 %h", done, busy, result,
               prev_result);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (result !== 16'h0000 || cout !== 1'b0 || zero16 !== 1'b1 || busy !== 1'b0 ||
        done !== 1'b0 || alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== 3'd0 ||
        alu_sc_in !== 1'b0) begin
      errors++;
      $display("FAIL %s got r=%h c=%b z=%b busy=%b done=%b alu=%h/%h/%0d/%b required reset values",
               name, result, cout, zero16, busy, done, alu_a, alu_b, alu_op, alu_sc_in);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; opw = 3'd0; a16 = 16'h0; b16 = 16'h0; cin = 1'b0;
    #3;
    check_reset_values("reset_state");
    start = 1'b1; opw = OP_ADD;
    step();
    check_reset_values("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    prev_result = 16'h0000;
    prev_cout   = 1'b0;
  endtask

  task automatic test_directed();
    run_op(OP_ADD, 16'h00FF, 16'h0001, 1'b0);
    run_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
    idle_check();
    run_op(OP_SUB, 16'h1000, 16'h0001, 1'b0);
    run_op(OP_SUB, 16'h0000, 16'h0001, 1'b1);
    run_op(OP_LSH, 16'h80B3, 16'hFFFF, 1'b1);
    run_op(OP_RSH, 16'h0101, 16'h1234, 1'b0);
    idle_check();
    run_op(3'b111, 16'hABCD, 16'h1234, 1'b1);
    idle_check();
  endtask

  task automatic test_random();
    logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) op = 3'($urandom_range(0, 7));
      else                           op = 3'($urandom_range(1, 5));
      run_op(op, 16'($urandom), 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_check();
    end
  endtask

  task automatic test_ignore_start();
    int ndone;
    logic [15:0] exp_r;
    logic        exp_c;
    ref_op(OP_ADD, 16'h1234, 16'h4321, 1'b1, exp_r, exp_c);
    opw = OP_ADD; a16 = 16'h1234; b16 = 16'h4321; cin = 1'b1; start = 1'b1;
    step();
    a16 = 16'hFFFF; b16 = 16'hFFFF; opw = OP_AND;
    step();
    step();
    start = 1'b0;
    ndone = int'(done);
    checks++;
    if (result !== exp_r || cout !== exp_c) begin
      errors++;
      $display("FAIL ignore_start_result got %h/%b required %h/%b", result, cout, exp_r, exp_c);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      ndone += int'(done);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL ignore_start_dones got %0d required 1", ndone);
    end
    prev_result = exp_r;
    prev_cout   = exp_c;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [6];
    logic [15:0] as [6], bs [6];
    logic        cs [6];
    logic [15:0] exp_r;
    logic        exp_c;
    for (int k = 0; k < 6; k++) begin
      ops[k] = (k % 2 == 0) ? OP_AND : OP_ADD;
      as[k]  = (k % 2 == 0) ? 16'hF0F0 : 16'($urandom);
      bs[k]  = (k % 2 == 0) ? 16'h3C3C : 16'($urandom);
      cs[k]  = 1'($urandom);
    end
    opw = ops[0]; a16 = as[0]; b16 = bs[0]; cin = cs[0]; start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ref_op(ops[k], as[k], bs[k], cs[k], exp_r, exp_c);
      step();
      if (k < 5) begin
        opw = ops[k+1]; a16 = as[k+1]; b16 = bs[k+1]; cin = cs[k+1];
      end else begin
        start = 1'b0;
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_first k=%0d busy=%b done=%b required 1 0", k, busy, done);
      end
      step();
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_second k=%0d done=%b required 0", k, done);
      end
      step();
      checks++;
      if (done !== 1'b1 || result !== exp_r || cout !== exp_c) begin
        errors++;
        $display("FAIL b2b_done k=%0d done=%b got %h/%b required 1 %h/%b", k, done, result, cout,
                 exp_r, exp_c);
      end
      prev_result = exp_r;
      prev_cout   = exp_c;
    end
    idle_check();
  endtask

  task automatic test_reset_mid();
    int ndone;
    opw = OP_ADD; a16 = 16'h7777; b16 = 16'h1111; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid_immediate");
    @(negedge clk);
    rst_n = 1'b1;
    prev_result = 16'h0000;
    prev_cout   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      ndone += int'(done) + int'(busy);
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done got %0d done/busy cycles required 0", ndone);
    end
    run_op(OP_ADD, 16'h0001, 16'h0001, 1'b0);
    idle_check();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
